rx_scramble_ctrl: RTL and testbench



---
 rtl/rx_scramble_ctrl_if.sv | 22 ++
 rtl/rx_scramble_ctrl.sv | 131 +++++++++++++
 tb/tb_rx_scramble_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rx_scramble_ctrl_if.sv
// Early-symbol bus into the Rx descrambler control stage and the per-symbol
// descramble controls it returns to the data path.
interface rx_scramble_ctrl_if;
    logic       EarlyValid;
    logic [7:0] EarlyByte;
    logic       EarlyCtrl;
    logic       ScrambleEnable;
    logic       NextScramble;
    logic [7:0] NextScXor;
    logic       TsActive;
    logic       DisScrSeen;

    modport master (
        output EarlyValid, EarlyByte, EarlyCtrl, ScrambleEnable,
        input  NextScramble, NextScXor, TsActive, DisScrSeen
    );

    modport slave (
        input  EarlyValid, EarlyByte, EarlyCtrl, ScrambleEnable,
        output NextScramble, NextScXor, TsActive, DisScrSeen
    );
endinterface

// File: rtl/rx_scramble_ctrl.sv
// Rx descrambler control: tracks the receive LFSR one symbol early and hands the
// data path a registered descramble enable and XOR mask aligned with DecodeByte.
module rx_scramble_ctrl #(
    parameter logic [15:0] SEED        = 16'hFFFF,
    parameter int          TS_BODY_LEN = 15,
    parameter logic [7:0]  COM_CODE    = 8'hBC,
    parameter logic [7:0]  SKP_CODE    = 8'h1C,
    parameter logic [7:0]  PAD_CODE    = 8'hF7
) (
    input  logic              ClkPci,
    input  logic              Reset,
    rx_scramble_ctrl_if.slave bus
);

    localparam logic [4:0] TS_LEN   = 5'(TS_BODY_LEN);
    localparam logic [4:0] TS_CTRL  = 5'd5;

    logic [15:0] lfsr_r;
    logic [4:0]  ts_count_r;
    logic [4:0]  ts_idx_r;
    logic        dis_scr_r;
    logic        next_scramble_r;
    logic [7:0]  next_xor_r;
    logic        ts_active_r;

    logic [15:0] lfsr_s;
    logic [4:0]  ts_count_s;
    logic [4:0]  ts_idx_s;
    logic        dis_scr_s;
    logic        next_scramble_s;
    logic [7:0]  next_xor_s;
    logic [15:0] lfsr_adv_s;
    logic [7:0]  mask_s;

    // Eight serial Galois steps; mask bit i is the output of step i (LSB first).
    function automatic logic [23:0] lfsr_adv8(input logic [15:0] state);
        logic [15:0] s;
        logic [7:0]  m;
        s = state;
        m = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m[i] = s[15];
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
        end
        return {m, s};
    endfunction

    assign {mask_s, lfsr_adv_s} = lfsr_adv8(lfsr_r);

    // Next-state decode for the LFSR, TS tracking and descramble controls.
    always_comb begin
        lfsr_s          = lfsr_r;
        ts_count_s      = ts_count_r;
        ts_idx_s        = ts_idx_r;
        dis_scr_s       = dis_scr_r;
        next_scramble_s = 1'b0;
        next_xor_s      = next_xor_r;
        if (bus.EarlyValid) begin
            next_xor_s = mask_s;
            if (bus.EarlyCtrl) begin
                case (bus.EarlyByte)
                    COM_CODE: begin
                        lfsr_s     = SEED;
                        ts_count_s = TS_LEN;
                        ts_idx_s   = 5'd1;
                    end
                    SKP_CODE: begin
                        lfsr_s = lfsr_r;
                    end
                    default: begin
                        lfsr_s = lfsr_adv_s;
                        // PAD belongs to the TS body; any other K ends it.
                        if (ts_count_r != 5'd0) begin
                            if (bus.EarlyByte == PAD_CODE) begin
                                ts_count_s = ts_count_r - 5'd1;
                                ts_idx_s   = ts_idx_r + 5'd1;
                            end else begin
                                ts_count_s = 5'd0;
                                ts_idx_s   = 5'd0;
                            end
                        end else begin
                            ts_count_s = ts_count_r;
                        end
                    end
                endcase
            end else begin
                lfsr_s = lfsr_adv_s;
                if (ts_count_r != 5'd0) begin
                    ts_count_s = ts_count_r - 5'd1;
                    ts_idx_s   = ts_idx_r + 5'd1;
                    if (ts_idx_r == TS_CTRL) begin
                        dis_scr_s = bus.EarlyByte[3];
                    end else begin
                        dis_scr_s = dis_scr_r;
                    end
                end else begin
                    next_scramble_s = bus.ScrambleEnable & ~dis_scr_r;
                end
            end
        end else begin
            next_xor_s = next_xor_r;
        end
    end

    // State and registered outputs; reset overrides every input.
    always_ff @(posedge ClkPci) begin
        if (Reset) begin
            lfsr_r          <= SEED;
            ts_count_r      <= 5'd0;
            ts_idx_r        <= 5'd0;
            dis_scr_r       <= 1'b0;
            next_scramble_r <= 1'b0;
            next_xor_r      <= 8'h00;
            ts_active_r     <= 1'b0;
        end else begin
            lfsr_r          <= lfsr_s;
            ts_count_r      <= ts_count_s;
            ts_idx_r        <= ts_idx_s;
            dis_scr_r       <= dis_scr_s;
            next_scramble_r <= next_scramble_s;
            next_xor_r      <= next_xor_s;
            ts_active_r     <= (ts_count_s != 5'd0);
        end
    end

    assign bus.NextScramble = next_scramble_r;
    assign bus.NextScXor    = next_xor_r;
    assign bus.TsActive     = ts_active_r;
    assign bus.DisScrSeen   = dis_scr_r;

endmodule

// File: tb/tb_rx_scramble_ctrl.sv
// Directed bench for rx_scramble_ctrl: hand-computed masks plus a serial LFSR
// reference for the mask following a full training-set body.
module tb_rx_scramble_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    rx_scramble_ctrl_if bus ();

    rx_scramble_ctrl dut (
        .ClkPci (clk),
        .Reset  (rst),
        .bus    (bus)
    );

    function automatic logic [7:0] ref_mask(input int n);
        logic [15:0] r;
        logic [7:0]  m;
        r = 16'hFFFF;
        m = 8'h00;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 8; i++) begin
                m[i] = r[15];
                r = r[15] ? ((r << 1) ^ 16'h0039) : (r << 1);
            end
        end
        return m;
    endfunction

    task automatic tick(input logic v, input logic c, input logic [7:0] b);
        bus.EarlyValid = v;
        bus.EarlyCtrl  = c;
        bus.EarlyByte  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
    endtask

    // COM followed by a 15-symbol TS1 body; bytes 1-2 are PAD, byte 5 is training control.
    task automatic send_ts(input logic [7:0] b5);
        logic [7:0] b;
        logic       c;
        tick(1'b1, 1'b1, 8'hBC);
        n_cmp++;
        if (bus.TsActive !== 1'b1) begin n_bad++; $display("FAIL ts_com_active: got %b want 1", bus.TsActive); end
        for (int k = 1; k <= 15; k++) begin
            c = (k <= 2);
            b = (k <= 2) ? 8'hF7 : (k == 5) ? b5 : (k == 3) ? 8'h10 : (k == 4) ? 8'h02 : 8'h4A;
            tick(1'b1, c, b);
            n_cmp++;
            if (bus.NextScramble !== 1'b0) begin n_bad++; $display("FAIL ts_body_scr k=%0d: got %b want 0", k, bus.NextScramble); end
            n_cmp++;
            if (bus.TsActive !== (k < 15)) begin n_bad++; $display("FAIL ts_body_active k=%0d: got %b want %b", k, bus.TsActive, (k < 15)); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1'b1, 1'b0, 8'h55);
        tick(1'b1, 1'b1, 8'hBC);
        n_cmp++;
        if (bus.NextScramble !== 1'b0) begin n_bad++; $display("FAIL reset_scr: got %b want 0", bus.NextScramble); end
        n_cmp++;
        if (bus.NextScXor !== 8'h00) begin n_bad++; $display("FAIL reset_xor: got %h want 00", bus.NextScXor); end
        n_cmp++;
        if (bus.TsActive !== 1'b0) begin n_bad++; $display("FAIL reset_ts: got %b want 0", bus.TsActive); end
        n_cmp++;
        if (bus.DisScrSeen !== 1'b0) begin n_bad++; $display("FAIL reset_dis: got %b want 0", bus.DisScrSeen); end
        rst = 1'b0;
    endtask

    task automatic test_mask_seq();
        logic [7:0] exp_m [4];
        exp_m = '{8'hFF, 8'h17, 8'hC0, 8'h14};
        do_reset();
        tick(1'b1, 1'b1, 8'hBC);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 8'h00);
            n_cmp++;
            if (bus.NextScXor !== exp_m[i]) begin n_bad++; $display("FAIL mask_seq %0d: got %h want %h", i, bus.NextScXor, exp_m[i]); end
        end
    endtask

    task automatic test_skp();
        do_reset();
        tick(1'b1, 1'b1, 8'hBC);
        tick(1'b1, 1'b0, 8'h00);
        n_cmp++;
        if (bus.NextScXor !== 8'hFF) begin n_bad++; $display("FAIL skp_first: got %h want FF", bus.NextScXor); end
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1, 8'h1C);
            n_cmp++;
            if (bus.NextScramble !== 1'b0) begin n_bad++; $display("FAIL skp_scr %0d: got %b want 0", i, bus.NextScramble); end
            n_cmp++;
            if (bus.TsActive !== 1'b1) begin n_bad++; $display("FAIL skp_ts %0d: got %b want 1", i, bus.TsActive); end
        end
        tick(1'b1, 1'b0, 8'h00);
        n_cmp++;
        if (bus.NextScXor !== 8'h17) begin n_bad++; $display("FAIL skp_after: got %h want 17", bus.NextScXor); end
    endtask

    task automatic test_ts_body();
        do_reset();
        send_ts(8'h00);
        tick(1'b1, 1'b0, 8'h00);
        n_cmp++;
        if (bus.NextScramble !== 1'b1) begin n_bad++; $display("FAIL ts_after_scr: got %b want 1", bus.NextScramble); end
        n_cmp++;
        if (bus.NextScXor !== ref_mask(16)) begin n_bad++; $display("FAIL ts_after_xor: got %h want %h", bus.NextScXor, ref_mask(16)); end
    endtask

    task automatic test_dis_scr();
        do_reset();
        send_ts(8'h08);
        n_cmp++;
        if (bus.DisScrSeen !== 1'b1) begin n_bad++; $display("FAIL dis_set: got %b want 1", bus.DisScrSeen); end
        tick(1'b1, 1'b1, 8'hBC);
        tick(1'b1, 1'b1, 8'hFB);
        tick(1'b1, 1'b0, 8'h00);
        n_cmp++;
        if (bus.NextScramble !== 1'b0) begin n_bad++; $display("FAIL dis_data_scr: got %b want 0", bus.NextScramble); end
        send_ts(8'h00);
        n_cmp++;
        if (bus.DisScrSeen !== 1'b0) begin n_bad++; $display("FAIL dis_clear: got %b want 0", bus.DisScrSeen); end
        tick(1'b1, 1'b0, 8'h00);
        n_cmp++;
        if (bus.NextScramble !== 1'b1) begin n_bad++; $display("FAIL dis_rescr: got %b want 1", bus.NextScramble); end
    endtask

    task automatic test_k_abort();
        do_reset();
        tick(1'b1, 1'b1, 8'hBC);
        tick(1'b1, 1'b0, 8'h00);
        n_cmp++;
        if (bus.TsActive !== 1'b1) begin n_bad++; $display("FAIL k_pre_ts: got %b want 1", bus.TsActive); end
        tick(1'b1, 1'b1, 8'hFB);
        n_cmp++;
        if (bus.TsActive !== 1'b0) begin n_bad++; $display("FAIL k_ts_clear: got %b want 0", bus.TsActive); end
        n_cmp++;
        if (bus.NextScramble !== 1'b0) begin n_bad++; $display("FAIL k_scr: got %b want 0", bus.NextScramble); end
        tick(1'b1, 1'b0, 8'h00);
        n_cmp++;
        if (bus.NextScramble !== 1'b1) begin n_bad++; $display("FAIL k_data_scr: got %b want 1", bus.NextScramble); end
        n_cmp++;
        if (bus.NextScXor !== 8'hC0) begin n_bad++; $display("FAIL k_data_xor: got %h want C0", bus.NextScXor); end
        bus.ScrambleEnable = 1'b0;
        tick(1'b1, 1'b0, 8'h00);
        n_cmp++;
        if (bus.NextScramble !== 1'b0) begin n_bad++; $display("FAIL k_en_off_scr: got %b want 0", bus.NextScramble); end
        n_cmp++;
        if (bus.NextScXor !== 8'h14) begin n_bad++; $display("FAIL k_en_off_xor: got %h want 14", bus.NextScXor); end
        bus.ScrambleEnable = 1'b1;
    endtask

    task automatic test_mid_reset();
        do_reset();
        tick(1'b1, 1'b1, 8'hBC);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h00);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 8'h00);
            n_cmp++;
            if ({bus.NextScramble, bus.NextScXor, bus.TsActive} !== 10'h000) begin
                n_bad++; $display("FAIL mid_reset %0d: got %b/%h/%b want 0/00/0", i, bus.NextScramble, bus.NextScXor, bus.TsActive);
            end
        end
        rst = 1'b0;
        tick(1'b1, 1'b1, 8'hBC);
        tick(1'b1, 1'b0, 8'h00);
        n_cmp++;
        if (bus.NextScXor !== 8'hFF) begin n_bad++; $display("FAIL mid_after: got %h want FF", bus.NextScXor); end
        tick(1'b0, 1'b0, 8'h00);
        n_cmp++;
        if (bus.NextScXor !== 8'hFF) begin n_bad++; $display("FAIL gap_hold: got %h want FF", bus.NextScXor); end
        n_cmp++;
        if (bus.NextScramble !== 1'b0) begin n_bad++; $display("FAIL gap_scr: got %b want 0", bus.NextScramble); end
        tick(1'b1, 1'b0, 8'h00);
        n_cmp++;
        if (bus.NextScXor !== 8'h17) begin n_bad++; $display("FAIL gap_next: got %h want 17", bus.NextScXor); end
    endtask

    initial begin
        bus.EarlyValid     = 1'b0;
        bus.EarlyCtrl      = 1'b0;
        bus.EarlyByte      = 8'h00;
        bus.ScrambleEnable = 1'b1;
        test_reset();
        test_mask_seq();
        test_skp();
        test_ts_body();
        test_dis_scr();
        test_k_abort();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
